// File: rtl/mux_collector_pkg.sv
// Shared widths, output slot state encoding and popcount helper for the
// mux bit collector.
package mux_collector_pkg;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 3;
   localparam int ONES_W = $clog2(DATA_W + 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slotState_e;

   function automatic logic [ONES_W-1:0] countOnes(input logic [DATA_W-1:0] value);
      logic [ONES_W-1:0] total;
      total = '0;
      for (int i = 0; i < DATA_W; i++) begin
         total = total + ONES_W'(value[i]);
      end
      return total;
   endfunction

endpackage

// File: rtl/mux_bit_shifter.sv
// Serial-to-parallel front end: shifts accepted bits in MSB-first and flags
// the cycle on which the eighth bit of a byte arrives.
module mux_bit_shifter
   import mux_collector_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              bit_i,
   input  logic              bitValid_i,
   output logic              byteDone_o,
   output logic [DATA_W-1:0] byteValue_o
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
   logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;

   // Clear outranks a coincident valid bit, so that bit is simply dropped.
   always_comb begin
      shiftReg_d = shiftReg_q;
      bitCnt_d   = bitCnt_q;
      if (clear_i) begin
         shiftReg_d = '0;
         bitCnt_d   = '0;
      end else if (bitValid_i) begin
         shiftReg_d = {shiftReg_q[DATA_W-2:0], bit_i};
         bitCnt_d   = bitCnt_q + CNT_W'(1);
      end
   end

   assign byteDone_o  = bitValid_i && !clear_i && (bitCnt_q == LAST_BIT);
   assign byteValue_o = {shiftReg_q[DATA_W-2:0], bit_i};

   always_ff @(posedge clk) begin
      if (rst) begin
         shiftReg_q <= '0;
         bitCnt_q   <= '0;
      end else begin
         shiftReg_q <= shiftReg_d;
         bitCnt_q   <= bitCnt_d;
      end
   end

endmodule

// File: rtl/mux_bit_collector.sv
// Collects and_mux result bits into bytes behind a one-entry output slot.
// Define MUX_BIT_COLLECTOR_ONES_COUNT_EN to add the registered ones_count output.
module mux_bit_collector
   import mux_collector_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              e_in,
   input  logic              e_valid,
   input  logic              clear,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow
`ifdef MUX_BIT_COLLECTOR_ONES_COUNT_EN
   ,
   output logic [ONES_W-1:0] ones_count
`endif
);

   logic              byteDone;
   logic [DATA_W-1:0] byteValue;
   slotState_e        slot_q;
   logic [DATA_W-1:0] outData_q;
   logic              overflow_q;

   mux_bit_shifter uShifter (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (clear),
      .bit_i       (e_in),
      .bitValid_i  (e_valid),
      .byteDone_o  (byteDone),
      .byteValue_o (byteValue)
   );

   // A byte finishing while the slot is held (FULL, not ready) is lost and
   // latches overflow until reset; a consume and a finish together reload.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q     <= EMPTY;
         outData_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (slot_q)
            EMPTY: begin
               if (byteDone) begin
                  slot_q    <= FULL;
                  outData_q <= byteValue;
               end
            end
            FULL: begin
               if (byteDone && out_ready) begin
                  outData_q <= byteValue;
               end else if (byteDone) begin
                  overflow_q <= 1'b1;
               end else if (out_ready) begin
                  slot_q <= EMPTY;
               end
            end
            default: slot_q <= EMPTY;
         endcase
      end
   end

`ifdef MUX_BIT_COLLECTOR_ONES_COUNT_EN
   logic [ONES_W-1:0] onesCount_q;

   // Updated on exactly the edges that load outData_q so the two stay paired.
   always_ff @(posedge clk) begin
      if (rst) begin
         onesCount_q <= '0;
      end else if (byteDone && (slot_q == EMPTY || out_ready)) begin
         onesCount_q <= countOnes(byteValue);
      end
   end

   assign ones_count = onesCount_q;
`endif

   assign out_data  = outData_q;
   assign out_valid = (slot_q == FULL);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_mux_bit_collector.sv
// Directed self-checking bench for mux_bit_collector; ones_count is checked
// only when MUX_BIT_COLLECTOR_ONES_COUNT_EN is defined.
module tb_mux_bit_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       e_in = 1'b0;
   logic       e_valid = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       overflow;
`ifdef MUX_BIT_COLLECTOR_ONES_COUNT_EN
   logic [3:0] ones_count;
`endif

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   mux_bit_collector dut (
      .clk       (clk),
      .rst       (rst),
      .e_in      (e_in),
      .e_valid   (e_valid),
      .clear     (clear),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow)
`ifdef MUX_BIT_COLLECTOR_ONES_COUNT_EN
      ,
      .ones_count(ones_count)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge; the task returns one full cycle later.
   task automatic applyStimulus(input logic rstV, input logic clrV, input logic vldV,
                                input logic bitV, input logic rdyV);
      rst       = rstV;
      clear     = clrV;
      e_valid   = vldV;
      e_in      = bitV;
      out_ready = rdyV;
      @(negedge clk);
   endtask

   task automatic sendByte(input logic [7:0] value, input logic rdyV);
      for (int i = 7; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, value[i], rdyV);
   endtask

   task automatic checkSlot(input string tag, input logic vld, input logic [7:0] data,
                            input logic ovf, input logic [3:0] ones);
      checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
      checkOutput({tag, ".data"}, {24'd0, out_data}, {24'd0, data});
      checkOutput({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ovf});
`ifdef MUX_BIT_COLLECTOR_ONES_COUNT_EN
      checkOutput({tag, ".ones"}, {28'd0, ones_count}, {28'd0, ones});
`else
      if (ones > 4'd8) $display("[TB] note: ones value %0d unused", ones);
`endif
   endtask

   initial begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkSlot("reset", 1'b0, 8'h00, 1'b0, 4'd0);

      sendByte(8'hB2, 1'b0);
      checkSlot("firstByte", 1'b1, 8'hB2, 1'b0, 4'd4);

      sendByte(8'hFF, 1'b0);
      checkSlot("dropFF", 1'b1, 8'hB2, 1'b1, 4'd4);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkSlot("consumeKeepsOvf", 1'b0, 8'hB2, 1'b1, 4'd4);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkSlot("ovfReset", 1'b0, 8'h00, 1'b0, 4'd0);

      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      sendByte(8'h0F, 1'b0);
      checkSlot("clearThen0F", 1'b1, 8'h0F, 1'b0, 4'd4);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("consume0F", {31'd0, out_valid}, 32'd0);
      sendByte(8'hA5, 1'b1);
      checkSlot("streamA5", 1'b1, 8'hA5, 1'b0, 4'd4);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("streamA5Taken", {31'd0, out_valid}, 32'd0);
      for (int i = 6; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C >> i & 1, 1'b1);
      checkSlot("stream3C", 1'b1, 8'h3C, 1'b0, 4'd4);

      sendByte(8'hC3, 1'b0);
      checkSlot("heldOvfC3", 1'b1, 8'h3C, 1'b1, 4'd4);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sendByte(8'h81, 1'b0);
      for (int i = 7; i >= 1; i--) applyStimulus(1'b0, 1'b0, 1'b1, 8'hE7 >> i & 1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkSlot("fullReload", 1'b1, 8'hE6, 1'b0, 4'd5);

      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, i[0], 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      checkSlot("midReset", 1'b0, 8'h00, 1'b0, 4'd0);
      sendByte(8'h5A, 1'b0);
      checkSlot("freshAfterReset", 1'b1, 8'h5A, 1'b0, 4'd4);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 8'h81 >> i & 1, 1'b0);
         if (i != 0) applyStimulus(1'b0, 1'b0, 1'b0, ~(8'h81 >> i & 1), 1'b0);
         if (i == 1) checkOutput("gapPartial", {31'd0, out_valid}, 32'd0);
      end
      checkSlot("gapped81", 1'b1, 8'h81, 1'b0, 4'd2);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
